// File: rtl/mips_multicycle_core.sv
// Multicycle MIPS core with a single shared ALU and one unified instruction/data memory port
// that uses a req/ack handshake.
//   CLK, RST (async, active-low)
//   mem_req/mem_we/mem_addr/mem_wdata : request side; held stable until the ack cycle
//   mem_rdata/mem_ack                 : response side; sampled on the edge where mem_ack = 1
//   halt                              : stopped on an unsupported opcode or funct
//   test_value                        : registered copy of GPR[TEST_REG][15:0]
module mips_multicycle_core #(
  parameter int unsigned RF_DEPTH = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [4:0]  TEST_REG = 5'd2
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        halt,
  output logic [15:0] test_value
);

  localparam logic [3:0] StIdle   = 4'd0;
  localparam logic [3:0] StFetch  = 4'd1;
  localparam logic [3:0] StDecode = 4'd2;
  localparam logic [3:0] StMemAdr = 4'd3;
  localparam logic [3:0] StMemRd  = 4'd4;
  localparam logic [3:0] StMemWb  = 4'd5;
  localparam logic [3:0] StMemWr  = 4'd6;
  localparam logic [3:0] StExec   = 4'd7;
  localparam logic [3:0] StAluWb  = 4'd8;
  localparam logic [3:0] StAddiWb = 4'd9;
  localparam logic [3:0] StBranch = 4'd10;
  localparam logic [3:0] StJump   = 4'd11;
  localparam logic [3:0] StHalt   = 4'd12;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  logic [3:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] alu_q, alu_d;
  logic [31:0] mdr_q, mdr_d;
  logic [15:0] tv_q;
  logic [31:0] rf_q [RF_DEPTH];

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm_sext;
  logic [31:0] rs_val, rt_val;
  logic [15:0] tv_val;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  assign op       = ir_q[31:26];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign funct    = ir_q[5:0];
  assign imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};

  // Entry 0 is never written, so it reads back 0; indices >= RF_DEPTH match nothing.
  always_comb begin
    rs_val = '0;
    rt_val = '0;
    tv_val = '0;
    for (int unsigned i = 0; i < RF_DEPTH; i++) begin
      if (rs == 5'(i))       rs_val = rf_q[i];
      if (rt == 5'(i))       rt_val = rf_q[i];
      if (TEST_REG == 5'(i)) tv_val = rf_q[i][15:0];
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    a_d      = a_q;
    b_d      = b_q;
    alu_d    = alu_q;
    mdr_d    = mdr_q;
    rf_we    = 1'b0;
    rf_waddr = rt;
    rf_wdata = alu_q;
    case (state_q)
      StIdle: state_d = StFetch;
      StFetch: begin
        if (mem_ack) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + 32'd4;
          state_d = StDecode;
        end
      end
      StDecode: begin
        a_d = rs_val;
        b_d = rt_val;
        case (op)
          OpLw, OpSw, OpAddi: state_d = StMemAdr;
          OpRtype:            state_d = StExec;
          OpBeq:              state_d = StBranch;
          OpJ:                state_d = StJump;
          default:            state_d = StHalt;
        endcase
      end
      StMemAdr: begin
        // addi shares the address adder with lw/sw
        alu_d = a_q + imm_sext;
        if (op == OpLw)      state_d = StMemRd;
        else if (op == OpSw) state_d = StMemWr;
        else                 state_d = StAddiWb;
      end
      StMemRd: begin
        if (mem_ack) begin
          mdr_d   = mem_rdata;
          state_d = StMemWb;
        end
      end
      StMemWb: begin
        rf_we    = 1'b1;
        rf_wdata = mdr_q;
        state_d  = StFetch;
      end
      StMemWr: begin
        if (mem_ack) state_d = StFetch;
      end
      StExec: begin
        state_d = StAluWb;
        case (funct)
          6'h20:   alu_d = a_q + b_q;
          6'h22:   alu_d = a_q - b_q;
          6'h24:   alu_d = a_q & b_q;
          6'h25:   alu_d = a_q | b_q;
          6'h2A:   alu_d = {31'd0, $signed(a_q) < $signed(b_q)};
          default: state_d = StHalt;
        endcase
      end
      StAluWb: begin
        rf_we    = 1'b1;
        rf_waddr = rd;
        state_d  = StFetch;
      end
      StAddiWb: begin
        rf_we   = 1'b1;
        state_d = StFetch;
      end
      StBranch: begin
        // pc_q already points at the delay-free successor (PC+4)
        if (a_q == b_q) pc_d = pc_q + {imm_sext[29:0], 2'b00};
        state_d = StFetch;
      end
      StJump: begin
        pc_d    = {pc_q[31:28], ir_q[25:0], 2'b00};
        state_d = StFetch;
      end
      StHalt:  state_d = StHalt;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      alu_q   <= '0;
      mdr_q   <= '0;
      tv_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      alu_q   <= alu_d;
      mdr_q   <= mdr_d;
      tv_q    <= tv_val;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int unsigned i = 0; i < RF_DEPTH; i++) rf_q[i] <= '0;
    end else if (rf_we) begin
      for (int unsigned i = 1; i < RF_DEPTH; i++) begin
        if (rf_waddr == 5'(i)) rf_q[i] <= rf_wdata;
      end
    end
  end

  // Memory port is decoded from registered state only, so it is stable through wait states.
  always_comb begin
    mem_req   = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);
    mem_we    = (state_q == StMemWr);
    mem_addr  = '0;
    mem_wdata = '0;
    if (state_q == StFetch) begin
      mem_addr = pc_q;
    end else if ((state_q == StMemRd) || (state_q == StMemWr)) begin
      mem_addr = alu_q;
    end
    if (state_q == StMemWr) mem_wdata = b_q;
  end

  assign halt       = (state_q == StHalt);
  assign test_value = tv_q;

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Bench for mips_multicycle_core: an instruction-level reference model predicts every memory
// access and test_value; a single negedge process serves memory and compares against it.
module tb_mips_multicycle_core;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        mem_req, mem_we, mem_ack, halt;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [15:0] test_value;

  logic        mem_req2, mem_we2, mem_ack2, halt2;
  logic [31:0] mem_addr2, mem_wdata2, mem_rdata2;
  logic [15:0] test_value2;

  mips_multicycle_core #(.RF_DEPTH(32), .RESET_PC(32'h40), .TEST_REG(5'd2)) dut (
    .CLK(CLK), .RST(RST), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .halt(halt),
    .test_value(test_value)
  );

  mips_multicycle_core #(.RF_DEPTH(8)) dut2 (
    .CLK(CLK), .RST(RST), .mem_req(mem_req2), .mem_we(mem_we2), .mem_addr(mem_addr2),
    .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata2), .mem_ack(mem_ack2), .halt(halt2),
    .test_value(test_value2)
  );

  initial forever #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ack_delay = 0;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    bit          fetch;
  } acc_t;

  logic [31:0] dmem  [1024];
  logic [31:0] m_mem [1024];
  logic [31:0] m_rf  [32];
  logic [31:0] m_pc;
  bit          m_halted;
  acc_t        expq[$];
  int          fetch_cyc[$];
  logic [31:0] fetch_addr[$];
  logic [31:0] rom2 [16];

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int fc(input int i);
    if (i < fetch_cyc.size()) return fetch_cyc[i];
    return -1000;
  endfunction

  function automatic logic [31:0] fa(input int i);
    if (i < fetch_addr.size()) return fetch_addr[i];
    return 32'hDEAD_BEEF;
  endfunction

  function automatic void m_wr(input logic [4:0] r, input logic [31:0] v);
    if (r != 5'd0) m_rf[r] = v;
  endfunction

  // Executes one whole instruction and queues the memory accesses it must produce.
  task automatic model_step();
    logic [31:0] ins, a, b, imm, ea;
    acc_t e;
    ins = m_mem[m_pc[11:2]];
    e.addr = m_pc; e.we = 1'b0; e.wdata = '0; e.fetch = 1'b1;
    expq.push_back(e);
    m_pc = m_pc + 32'd4;
    a   = m_rf[ins[25:21]];
    b   = m_rf[ins[20:16]];
    imm = {{16{ins[15]}}, ins[15:0]};
    ea  = a + imm;
    case (ins[31:26])
      6'h00: begin
        case (ins[5:0])
          6'h20:   m_wr(ins[15:11], a + b);
          6'h22:   m_wr(ins[15:11], a - b);
          6'h24:   m_wr(ins[15:11], a & b);
          6'h25:   m_wr(ins[15:11], a | b);
          6'h2A:   m_wr(ins[15:11], ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
          default: m_halted = 1'b1;
        endcase
      end
      6'h23: begin
        e.addr = ea; e.fetch = 1'b0;
        expq.push_back(e);
        m_wr(ins[20:16], m_mem[ea[11:2]]);
      end
      6'h2B: begin
        e.addr = ea; e.we = 1'b1; e.wdata = b; e.fetch = 1'b0;
        expq.push_back(e);
        m_mem[ea[11:2]] = b;
      end
      6'h04:   if (a == b) m_pc = m_pc + (imm << 2);
      6'h08:   m_wr(ins[20:16], ea);
      6'h02:   m_pc = {m_pc[31:28], ins[25:0], 2'b00};
      default: m_halted = 1'b1;
    endcase
  endtask

  task automatic model_reset();
    m_pc = 32'h40;
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    m_mem = dmem;
    expq.delete();
    fetch_cyc.delete();
    fetch_addr.delete();
    m_halted = 1'b0;
  endtask

  // Memory responder and per-cycle comparison against the model.
  initial begin
    int          cnt;
    bit          tv_pend;
    logic [15:0] tv_exp;
    logic [31:0] h_addr, h_wdata;
    logic        h_we;
    acc_t        e;
    cnt = 0; tv_pend = 0; tv_exp = '0; h_addr = '0; h_wdata = '0; h_we = 1'b0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge CLK);
      if (!RST) begin
        cnt = 0; mem_ack = 1'b0; tv_pend = 0;
        continue;
      end
      if (tv_pend) begin
        check32("test_value", {16'd0, test_value}, {16'd0, tv_exp});
        tv_pend = 0;
      end
      if (halt) check32("no_req_in_halt", {31'd0, mem_req}, 32'd0);
      if (!mem_req) begin
        cnt = 0;
        mem_ack = 1'b0;
      end else begin
        if (cnt == 0) begin
          h_addr = mem_addr; h_we = mem_we; h_wdata = mem_wdata;
        end else begin
          check32("addr_stable", mem_addr, h_addr);
          check32("we_stable", {31'd0, mem_we}, {31'd0, h_we});
          check32("wdata_stable", mem_wdata, h_wdata);
        end
        mem_ack = (cnt == ack_delay);
        if (mem_ack) begin
          cnt = 0;
          if (mem_we) dmem[mem_addr[11:2]] = mem_wdata;
          else        mem_rdata = dmem[mem_addr[11:2]];
          if (expq.size() == 0 && !m_halted) begin
            tv_exp  = m_rf[2][15:0];
            tv_pend = 1;
            model_step();
          end
          if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_req: got access at %h, required none", mem_addr);
          end else begin
            e = expq.pop_front();
            check32("acc_addr", mem_addr, e.addr);
            check32("acc_we", {31'd0, mem_we}, {31'd0, e.we});
            if (e.we) check32("acc_wdata", mem_wdata, e.wdata);
            if (e.fetch) begin
              fetch_cyc.push_back(cyc);
              fetch_addr.push_back(mem_addr);
            end
          end
        end else begin
          cnt++;
        end
      end
    end
  end

  // Second core: zero-wait ROM, RF_DEPTH = 8, default RESET_PC.
  initial begin
    mem_ack2 = 1'b1;
    mem_rdata2 = '0;
    for (int i = 0; i < 16; i++) rom2[i] = 32'hFC00_0000;
    rom2[0] = 32'h2009_0055;  // addi $9,$0,0x55 (dropped)
    rom2[1] = 32'h2007_0033;  // addi $7,$0,0x33
    rom2[2] = 32'h0127_1020;  // add  $2,$9,$7
    forever begin
      @(negedge CLK);
      mem_rdata2 = rom2[mem_addr2[5:2]];
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) dmem[i] = '0;
  endtask

  task automatic apply_reset();
    RST = 1'b0;
    model_reset();
    repeat (2) @(negedge CLK);
    check32("rst_req", {31'd0, mem_req}, 32'd0);
    check32("rst_we", {31'd0, mem_we}, 32'd0);
    check32("rst_addr", mem_addr, 32'd0);
    check32("rst_wdata", mem_wdata, 32'd0);
    check32("rst_halt", {31'd0, halt}, 32'd0);
    check32("rst_test_value", {16'd0, test_value}, 32'd0);
    @(posedge CLK);
    #1 RST = 1'b1;
  endtask

  task automatic wait_halt(input int bound);
    for (int i = 0; i < bound && !halt; i++) @(negedge CLK);
    check32("halt_reached", {31'd0, halt}, 32'd1);
  endtask

  initial begin
    bit found;
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    bit found;
    // Reset, first fetch and arithmetic
    clear_mem();
    dmem[16] = 32'h2002_0005;  // addi $2,$0,5
    dmem[17] = 32'h2003_0007;  // addi $3,$0,7
    dmem[18] = 32'h0043_1020;  // add  $2,$2,$3
    dmem[19] = 32'h0003_2022;  // sub  $4,$0,$3
    dmem[20] = 32'h0082_282A;  // slt  $5,$4,$2
    dmem[21] = 32'hAC04_0100;  // sw   $4,0x100($0)
    dmem[22] = 32'hAC05_0104;  // sw   $5,0x104($0)
    dmem[23] = 32'hFC00_0000;  // illegal
    ack_delay = 0;
    @(posedge CLK);
    #1;
    apply_reset();
    @(negedge CLK);
    check32("idle_no_req", {31'd0, mem_req}, 32'd0);
    @(negedge CLK);
    check32("first_req", {31'd0, mem_req}, 32'd1);
    check32("first_addr", mem_addr, 32'h40);
    check32("first_we", {31'd0, mem_we}, 32'd0);
    wait_halt(300);
    check32("arith_cycles", 32'(fc(5) - fc(0)), 32'd20);
    check32("sub_result", dmem[64], 32'hFFFF_FFF9);
    check32("slt_result", dmem[65], 32'd1);
    check32("arith_tv", {16'd0, test_value}, 32'h000C);
    check32("rf8_tv", {16'd0, test_value2}, 32'h0033);
    check32("rf8_halt", {31'd0, halt2}, 32'd1);

    // Store/load with three wait cycles per request
    clear_mem();
    dmem[16] = 32'h2002_1234;  // addi $2,$0,0x1234
    dmem[17] = 32'hAC02_0008;  // sw   $2,8($0)
    dmem[18] = 32'h8C06_0008;  // lw   $6,8($0)
    dmem[19] = 32'hAC06_0108;  // sw   $6,0x108($0)
    dmem[20] = 32'hFC00_0000;
    ack_delay = 3;
    @(posedge CLK);
    #1;
    apply_reset();
    wait_halt(400);
    check32("sw_data", dmem[2], 32'h1234);
    check32("lw_back", dmem[66], 32'h1234);
    check32("sw_cycles", 32'(fc(2) - fc(1)), 32'd10);
    check32("lw_cycles", 32'(fc(3) - fc(2)), 32'd11);
    check32("mem_tv", {16'd0, test_value}, 32'h1234);

    // Branches, jump, $0 write
    clear_mem();
    dmem[16]  = 32'h2003_0001;  // addi $3,$0,1
    dmem[17]  = 32'h1003_0005;  // beq  $0,$3,+5 (not taken)
    dmem[18]  = 32'h2000_0009;  // addi $0,$0,9
    dmem[19]  = 32'h0003_1020;  // add  $2,$0,$3
    dmem[20]  = 32'h0800_0100;  // j    0x100
    dmem[21]  = 32'hFC00_0000;
    dmem[256] = 32'h1000_FFFF;  // beq  $0,$0,-1
    ack_delay = 0;
    @(posedge CLK);
    #1;
    apply_reset();
    repeat (60) @(negedge CLK);
    check32("beq_fallthrough", fa(2), 32'h48);
    check32("jump_target", fa(5), 32'h400);
    check32("beq_loop1", fa(6), 32'h400);
    check32("beq_loop2", fa(7), 32'h400);
    check32("zero_reg_tv", {16'd0, test_value}, 32'd1);
    check32("loop_no_halt", {31'd0, halt}, 32'd0);

    // Reset during a pending load, then halt and reset out of halt
    clear_mem();
    dmem[2]  = 32'hCAFE_0001;
    dmem[16] = 32'h8C06_0008;  // lw $6,8($0)
    dmem[17] = 32'hFC00_0000;
    ack_delay = 3;
    @(posedge CLK);
    #1;
    apply_reset();
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge CLK);
      found = mem_req && !mem_we && (mem_addr == 32'h8);
    end
    check32("lw_pending_seen", {31'd0, found}, 32'd1);
    #2 RST = 1'b0;
    #1;
    check32("abort_req", {31'd0, mem_req}, 32'd0);
    model_reset();
    @(posedge CLK);
    #1 RST = 1'b1;
    @(negedge CLK);
    check32("restart_idle", {31'd0, mem_req}, 32'd0);
    @(negedge CLK);
    check32("restart_req", {31'd0, mem_req}, 32'd1);
    check32("restart_addr", mem_addr, 32'h40);
    wait_halt(100);
    repeat (10) @(negedge CLK);
    check32("halt_held", {31'd0, halt}, 32'd1);
    #2 RST = 1'b0;
    #1;
    check32("halt_cleared", {31'd0, halt}, 32'd0);
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    repeat (2) @(negedge CLK);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
